// File: rtl/rs_encoder_16_8.sv
// Systematic RS(N_NUM, N_NUM-R_NUM) encoder over GF(2^8), field polynomial 0x11D.
// Optional ENC_ERR_INJECT_EN adds inj_loc/inj_val ports that corrupt one output symbol.
module rs_encoder_16_8 #(
    parameter int unsigned SYM_BW = 8,
    parameter int unsigned N_NUM  = 255,
    parameter int unsigned R_NUM  = 16,
    parameter int unsigned T_NUM  = R_NUM / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              data_in_val,
    input  logic [SYM_BW-1:0] data_in,
`ifdef ENC_ERR_INJECT_EN
    input  logic [SYM_BW-1:0] inj_loc,
    input  logic [SYM_BW-1:0] inj_val,
`endif
    output logic              data_in_rdy,
    output logic [SYM_BW-1:0] symb_out_cnt,
    output logic              symb_out_val,
    output logic [SYM_BW-1:0] symb_out
);

    localparam int unsigned       K_NUM    = N_NUM - R_NUM;
    localparam logic [SYM_BW-1:0] K_CNT    = SYM_BW'(K_NUM);
    localparam logic [SYM_BW-1:0] N_CNT    = SYM_BW'(N_NUM);
    localparam logic [SYM_BW-1:0] POLY_LOW = SYM_BW'('h1D);
    localparam logic [SYM_BW-1:0] ONE      = SYM_BW'(1);

    if (SYM_BW != 8 || T_NUM * 2 != R_NUM || R_NUM >= N_NUM || N_NUM > 255) begin : g_bad_cfg
        $error("rs_encoder_16_8: unsupported parameter set");
    end

    // Shift-and-add multiply; with one operand constant it reduces to an XOR network.
    function automatic logic [SYM_BW-1:0] gf_mul(input logic [SYM_BW-1:0] a,
                                                 input logic [SYM_BW-1:0] b);
        logic [SYM_BW-1:0] acc;
        logic [SYM_BW-1:0] sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < SYM_BW; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = {sh[SYM_BW-2:0], 1'b0} ^ (sh[SYM_BW-1] ? POLY_LOW : '0);
        end
        return acc;
    endfunction

    // Expands prod (x + alpha^i); returns g_0..g_{R-1} (g_R is 1 and implicit).
    function automatic logic [R_NUM*SYM_BW-1:0] gen_poly();
        logic [SYM_BW-1:0]       g [R_NUM+1];
        logic [SYM_BW-1:0]       root;
        logic [R_NUM*SYM_BW-1:0] res;
        for (int j = 0; j <= R_NUM; j++) g[j] = '0;
        g[0] = ONE;
        root = ONE;
        for (int i = 0; i < R_NUM; i++) begin
            for (int j = R_NUM; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, SYM_BW'(2));
        end
        res = '0;
        for (int j = 0; j < R_NUM; j++) res[j*SYM_BW +: SYM_BW] = g[j];
        return res;
    endfunction

    localparam logic [R_NUM*SYM_BW-1:0] G_COEF = gen_poly();

    typedef enum logic [1:0] {StIdle, StMsg, StPar} state_e;

    state_e            state_q, state_d;
    logic [SYM_BW-1:0] par_q [R_NUM];
    logic [SYM_BW-1:0] par_d [R_NUM];
    logic [SYM_BW-1:0] par_src [R_NUM];
    logic [SYM_BW-1:0] cnt_q, cnt_d, cnt_next;
    logic [SYM_BW-1:0] fb;
    logic [SYM_BW-1:0] out_cnt_q, out_cnt_d;
    logic [SYM_BW-1:0] out_sym_q, out_sym_d;
    logic              out_val_q, out_val_d;
    logic              accept, restart;

`ifdef ENC_ERR_INJECT_EN
    logic [SYM_BW-1:0] inj_loc_q, inj_loc_d, inj_val_q, inj_val_d;
    logic [SYM_BW-1:0] inj_loc_eff, inj_val_eff;
`endif

    assign data_in_rdy = (state_q != StPar);
    assign accept      = data_in_val & data_in_rdy;
    assign restart     = accept & start;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_next  = cnt_q + ONE;
        par_d     = par_q;
        par_src   = par_q;
        fb        = '0;
        out_val_d = 1'b0;
        out_cnt_d = '0;
        out_sym_d = '0;

        case (state_q)
            StIdle, StMsg: begin
                if (accept && (start || state_q == StMsg)) begin
                    // A start accept restarts the codeword from an empty remainder.
                    if (restart) begin
                        for (int i = 0; i < R_NUM; i++) par_src[i] = '0;
                        cnt_next = ONE;
                    end
                    fb = data_in ^ par_src[R_NUM-1];
                    for (int i = 0; i < R_NUM; i++) begin
                        par_d[i] = ((i == 0) ? '0 : par_src[(i == 0) ? 0 : i-1])
                                   ^ gf_mul(G_COEF[i*SYM_BW +: SYM_BW], fb);
                    end
                    cnt_d     = cnt_next;
                    out_val_d = 1'b1;
                    out_cnt_d = cnt_next;
                    out_sym_d = data_in;
                    state_d   = (cnt_next == K_CNT) ? StPar : StMsg;
                end
            end
            StPar: begin
                out_val_d = 1'b1;
                out_cnt_d = cnt_next;
                out_sym_d = par_q[R_NUM-1];
                for (int i = R_NUM - 1; i > 0; i--) par_d[i] = par_q[i-1];
                par_d[0] = '0;
                if (cnt_next == N_CNT) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    for (int i = 0; i < R_NUM; i++) par_d[i] = '0;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                for (int i = 0; i < R_NUM; i++) par_d[i] = '0;
            end
        endcase

`ifdef ENC_ERR_INJECT_EN
        inj_loc_d   = restart ? inj_loc : inj_loc_q;
        inj_val_d   = restart ? inj_val : inj_val_q;
        inj_loc_eff = inj_loc_d;
        inj_val_eff = inj_val_d;
        // Only the output copy is corrupted; the LFSR above was fed clean data.
        if (out_val_d && (out_cnt_d - ONE) == inj_loc_eff) begin
            out_sym_d = out_sym_d ^ inj_val_eff;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            out_val_q <= 1'b0;
            out_cnt_q <= '0;
            out_sym_q <= '0;
            for (int i = 0; i < R_NUM; i++) par_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_val_q <= out_val_d;
            out_cnt_q <= out_cnt_d;
            out_sym_q <= out_sym_d;
            for (int i = 0; i < R_NUM; i++) par_q[i] <= par_d[i];
        end
    end

`ifdef ENC_ERR_INJECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_loc_q <= '0;
            inj_val_q <= '0;
        end else begin
            inj_loc_q <= inj_loc_d;
            inj_val_q <= inj_val_d;
        end
    end
`endif

    assign symb_out_val = out_val_q;
    assign symb_out_cnt = out_cnt_q;
    assign symb_out     = out_sym_q;

endmodule

// File: tb/tb_rs_encoder_16_8.sv
// Scoreboard bench for rs_encoder_16_8: a polynomial long-division model predicts each
// codeword; a monitor compares every output cycle against the expected queue.
module tb_rs_encoder_16_8;

    localparam int N = 255;
    localparam int R = 16;
    localparam int K = N - R;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       data_in_val = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_rdy;
    logic [7:0] symb_out_cnt;
    logic       symb_out_val;
    logic [7:0] symb_out;
`ifdef ENC_ERR_INJECT_EN
    logic [7:0] inj_loc = 8'h00;
    logic [7:0] inj_val = 8'h00;
`endif

    rs_encoder_16_8 #(.SYM_BW(8), .N_NUM(N), .R_NUM(R), .T_NUM(R / 2)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .data_in_val  (data_in_val),
        .data_in      (data_in),
`ifdef ENC_ERR_INJECT_EN
        .inj_loc      (inj_loc),
        .inj_val      (inj_val),
`endif
        .data_in_rdy  (data_in_rdy),
        .symb_out_cnt (symb_out_cnt),
        .symb_out_val (symb_out_val),
        .symb_out     (symb_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cnt;
        logic [7:0] sym;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         gexp[255];
    int         glog[256];
    int         gpoly[R+1];
    logic [7:0] msg[K];
    logic [7:0] msg_a[K];
    logic [7:0] cw[N];
    int         cap_sel = -1;
    logic [7:0] cap[3][N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int gm(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    function automatic void build_model();
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
        end
        for (int j = 0; j <= R; j++) gpoly[j] = (j == 0) ? 1 : 0;
        for (int i = 0; i < R; i++) begin
            for (int j = R; j > 0; j--) gpoly[j] = gpoly[j-1] ^ gm(gpoly[j], gexp[i]);
            gpoly[0] = gm(gpoly[0], gexp[i]);
        end
    endfunction

    // cw[0] is the highest-degree coefficient of m(x)*x^R; after division the tail is the
    // remainder, highest degree first.
    function automatic void encode();
        int w[N];
        int coef;
        for (int j = 0; j < N; j++) w[j] = (j < K) ? int'(msg[j]) : 0;
        for (int j = 0; j < K; j++) begin
            coef = w[j];
            if (coef != 0) begin
                for (int t = 0; t <= R; t++) w[j+t] = w[j+t] ^ gm(coef, gpoly[R-t]);
            end
        end
        for (int j = 0; j < N; j++) cw[j] = (j < K) ? msg[j] : 8'(w[j]);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (symb_out_val) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=cnt %0d sym %0h required=none",
                             symb_out_cnt, symb_out);
                end else begin
                    e = exp_q.pop_front();
                    check("out_cnt", {24'd0, symb_out_cnt}, {24'd0, e.cnt});
                    check("out_sym", {24'd0, symb_out}, {24'd0, e.sym});
                    check("rdy_busy", {31'd0, data_in_rdy},
                          {31'd0, !(int'(e.cnt) >= K && int'(e.cnt) < N)});
                    if (cap_sel >= 0 && e.cnt != 0) cap[cap_sel][int'(e.cnt) - 1] = symb_out;
                end
            end else begin
                check("idle_cnt", {24'd0, symb_out_cnt}, 32'd0);
                check("idle_sym", {24'd0, symb_out}, 32'd0);
                check("idle_rdy", {31'd0, data_in_rdy}, 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_sym(input logic [7:0] d, input logic st, input int gap_max);
        repeat ($urandom_range(0, gap_max)) begin
            data_in_val = 1'b0;
            data_in     = 8'($urandom);
            start       = 1'($urandom);
            step();
        end
        data_in_val = 1'b1;
        data_in     = d;
        start       = st;
        step();
        data_in_val = 1'b0;
        start       = 1'b0;
    endtask

    // Junk with start=1 during parity must be neither accepted nor restart anything.
    task automatic wait_rdy();
        int n;
        n = 0;
        while (!data_in_rdy && n < 100) begin
            data_in_val = 1'($urandom);
            start       = 1'($urandom);
            data_in     = 8'($urandom);
            step();
            n++;
        end
        data_in_val = 1'b0;
        start       = 1'b0;
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout actual=%0d cycles required=<100", n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        step();
    endtask

    task automatic push_codeword();
        encode();
        for (int j = 0; j < N; j++) exp_q.push_back({8'(j + 1), cw[j]});
    endtask

    task automatic run_codeword(input int gap_max);
        push_codeword();
        for (int j = 0; j < K; j++) send_sym(msg[j], j == 0, gap_max);
        wait_rdy();
        drain();
    endtask

    task automatic rand_msg();
        for (int j = 0; j < K; j++) msg[j] = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_val"}, {31'd0, symb_out_val}, 32'd0);
        check({tag, "_cnt"}, {24'd0, symb_out_cnt}, 32'd0);
        check({tag, "_sym"}, {24'd0, symb_out}, 32'd0);
        check({tag, "_rdy"}, {31'd0, data_in_rdy}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build_model();
        #12;
        check_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        step();

        // Symbols without start in IDLE are dropped.
        for (int j = 0; j < 3; j++) send_sym(8'($urandom), 1'b0, 0);
        repeat (3) step();

        for (int j = 0; j < K; j++) msg[j] = 8'h00;
        run_codeword(0);

        msg[K-1] = 8'h01;
        run_codeword(0);

        for (int c = 0; c < 4; c++) begin
            rand_msg();
            run_codeword(c);
        end

        rand_msg();
        for (int j = 0; j < K; j++) msg_a[j] = msg[j];
        cap_sel = 0;
        run_codeword(2);
        rand_msg();
        cap_sel = 1;
        run_codeword(1);
        for (int j = 0; j < K; j++) msg[j] = msg[j] ^ msg_a[j];
        cap_sel = 2;
        run_codeword(0);
        cap_sel = -1;
        for (int j = 0; j < N; j++) check("linearity", {24'd0, cap[0][j] ^ cap[1][j]},
                                         {24'd0, cap[2][j]});

        // Abort after 100 message symbols, then a complete codeword via start in MSG.
        rand_msg();
        for (int j = 0; j < 100; j++) exp_q.push_back({8'(j + 1), msg[j]});
        for (int j = 0; j < 100; j++) send_sym(msg[j], j == 0, 1);
        rand_msg();
        run_codeword(1);

        // Reset in the middle of the parity phase.
        rand_msg();
        push_codeword();
        for (int j = 0; j < K; j++) send_sym(msg[j], j == 0, 0);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_reset_outputs("midpar_rst");
        step();
        check_reset_outputs("midpar_rst_edge");
        rst_n = 1'b1;
        step();
        rand_msg();
        run_codeword(2);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
